// File: rtl/internalram_bus_if.sv
// Bus bundle between the 68k-side master and the on-chip RAM slave.
// The master holds cs until it sees ack, then drops it for at least one edge.
interface internalram_bus_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                  cs;
  logic                  rw;
  logic [31:0]           addr;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack;

  modport master (
    output cs, rw, addr, be, data_in,
    input  data_out, ack
  );

  modport slave (
    input  cs, rw, addr, be, data_in,
    output data_out, ack
  );
endinterface

// File: rtl/internalram_bus.sv
// On-chip RAM slave: one BRAM per byte lane, select/acknowledge handshake,
// byte-lane write enables and a programmable number of wait states.
module internalram_bus #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             reset,
  internalram_bus_if.slave bus
);
  localparam int         LANES     = DATA_WIDTH / 8;
  localparam int         LANE_BITS = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_ack;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_rw;
  logic [LANES-1:0]      r_be;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_addr;

  // Upper address bits are dropped, so the window aliases modulo the depth.
  assign w_idx         = bus.addr[LANE_BITS +: ADDR_WIDTH];
  assign w_unused_addr = &{1'b0, bus.addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cs) begin
            r_idx   <= w_idx;
            r_rw    <= bus.rw;
            r_be    <= bus.be;
            r_wdata <= bus.data_in;
            r_cnt   <= WS;
            r_state <= (WS != 4'd0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (!bus.cs)
            r_state <= S_IDLE;
          else if (r_cnt == 4'd1)
            r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          r_state <= S_ACK;
        end
        S_ACK: begin
          // ack is raised on the first ACK cycle regardless of cs, so the
          // master always sees at least one acknowledged cycle.
          if (!bus.cs && r_ack) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
          end else begin
            r_ack   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Reset in the ACCESS cycle must not corrupt the addressed word.
  assign w_wr_en = (r_state == S_ACCESS) && !r_rw && !reset;
  assign w_rd_en = (r_state == S_ACCESS) && r_rw;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_rd;

      always_ff @(posedge clk) begin
        if (w_wr_en && r_be[gi])
          r_mem[r_idx] <= r_wdata[8*gi +: 8];
      end

      always_ff @(posedge clk) begin
        if (reset)
          r_rd <= 8'h00;
        else if (w_rd_en)
          r_rd <= r_mem[r_idx];
      end

      assign w_rdata[8*gi +: 8] = r_rd;
    end
  endgenerate

  assign bus.ack      = r_ack;
  assign bus.data_out = w_rdata;
endmodule

// File: tb/tb_internalram_bus.sv
// Directed bench: a zero-wait-state instance and a three-wait-state instance
// sharing clock and reset, exercised one scenario task at a time.
module tb_internalram_bus;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  internalram_bus_if #(.DATA_WIDTH(16)) bus0 ();
  internalram_bus_if #(.DATA_WIDTH(16)) bus3 ();

  internalram_bus #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  internalram_bus #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_bus(input int dut, input logic c, input logic r,
                         input logic [31:0] a, input logic [1:0] b,
                         input logic [15:0] d);
    if (dut == 0) begin
      bus0.cs = c; bus0.rw = r; bus0.addr = a; bus0.be = b; bus0.data_in = d;
    end else begin
      bus3.cs = c; bus3.rw = r; bus3.addr = a; bus3.be = b; bus3.data_in = d;
    end
  endtask

  task automatic drop_cs(input int dut);
    if (dut == 0) bus0.cs = 1'b0;
    else          bus3.cs = 1'b0;
  endtask

  function automatic logic get_ack(input int dut);
    return (dut == 0) ? bus0.ack : bus3.ack;
  endfunction

  function automatic logic [15:0] get_data(input int dut);
    return (dut == 0) ? bus0.data_out : bus3.data_out;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full handshake; called and returns #1 after a rising edge.
  // lat = edges after the sampling edge until ack is seen high.
  task automatic do_xfer(input int dut, input logic r, input logic [31:0] a,
                         input logic [1:0] b, input logic [15:0] d,
                         output int lat, output logic [15:0] dout,
                         output logic ack_after);
    set_bus(dut, 1'b1, r, a, b, d);
    tick();
    lat = 0;
    while (!get_ack(dut) && lat < 40) begin
      tick();
      lat++;
    end
    dout = get_data(dut);
    drop_cs(dut);
    tick();
    ack_after = get_ack(dut);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_bus(0, 1'b0, 1'b1, 32'h0, 2'b00, 16'h0);
    set_bus(3, 1'b0, 1'b1, 32'h0, 2'b00, 16'h0);
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus0.ack !== 1'b0 || bus3.ack !== 1'b0) begin
        bad++;
        $display("FAIL reset_ack cycle %0d: got %b/%b want 0/0", i, bus0.ack, bus3.ack);
      end
      total++;
      if (bus0.data_out !== 16'h0000 || bus3.data_out !== 16'h0000) begin
        bad++;
        $display("FAIL reset_data cycle %0d: got %h/%h want 0000/0000", i, bus0.data_out, bus3.data_out);
      end
    end
    $display("reset: idle 5 cycles checked");
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] d; logic aa;
    do_xfer(0, 1'b0, 32'h0000_0010, 2'b11, 16'hBEEF, lat, d, aa);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
    total++;
    if (aa !== 1'b0) begin bad++; $display("FAIL wr_ack_fall: got %b want 0", aa); end
    $display("write addr=00000010 be=11 data=beef lat=%0d", lat);
    do_xfer(0, 1'b1, 32'h0000_0010, 2'b00, 16'h0000, lat, d, aa);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
    total++;
    if (d !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want beef", d); end
    $display("read  addr=00000010 data=%h lat=%0d", d, lat);
  endtask

  task automatic test_byte_lanes();
    int lat; logic [15:0] d; logic aa;
    do_xfer(0, 1'b0, 32'h0000_0010, 2'b10, 16'h12AB, lat, d, aa);
    total++;
    if (bus0.data_out !== 16'hBEEF) begin bad++; $display("FAIL wr_keeps_dout: got %h want beef", bus0.data_out); end
    do_xfer(0, 1'b1, 32'h0000_0010, 2'b00, 16'h0000, lat, d, aa);
    total++;
    if (d !== 16'h12EF) begin bad++; $display("FAIL lane_hi: got %h want 12ef", d); end
    $display("write be=10 data=12ab -> read %h", d);
    do_xfer(0, 1'b0, 32'h0000_0010, 2'b01, 16'hCD34, lat, d, aa);
    do_xfer(0, 1'b1, 32'h0000_0010, 2'b00, 16'h0000, lat, d, aa);
    total++;
    if (d !== 16'h1234) begin bad++; $display("FAIL lane_lo: got %h want 1234", d); end
    $display("write be=01 data=cd34 -> read %h", d);
    do_xfer(0, 1'b0, 32'h0000_0010, 2'b00, 16'hFFFF, lat, d, aa);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL be0_ack: got latency %0d want 2", lat); end
    do_xfer(0, 1'b1, 32'h0000_0010, 2'b00, 16'h0000, lat, d, aa);
    total++;
    if (d !== 16'h1234) begin bad++; $display("FAIL be0_noop: got %h want 1234", d); end
    $display("write be=00 data=ffff -> read %h", d);
  endtask

  task automatic test_alias();
    int lat; logic [15:0] d; logic aa;
    do_xfer(0, 1'b0, 32'h0000_0002, 2'b11, 16'hA5A5, lat, d, aa);
    do_xfer(0, 1'b1, 32'h0000_2002, 2'b00, 16'h0000, lat, d, aa);
    total++;
    if (d !== 16'hA5A5) begin bad++; $display("FAIL alias: got %h want a5a5", d); end
    $display("alias write 00000002 read 00002002 -> %h", d);
  endtask

  task automatic test_wait_hold();
    int lat; logic [15:0] d; logic aa;
    do_xfer(3, 1'b0, 32'h0000_0040, 2'b11, 16'h5A3C, lat, d, aa);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL ws_wr_latency: got %0d want 5", lat); end
    set_bus(3, 1'b1, 1'b1, 32'h0000_0040, 2'b00, 16'h0000);
    tick();
    lat = 0;
    while (!bus3.ack && lat < 40) begin tick(); lat++; end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL ws_rd_latency: got %0d want 5", lat); end
    total++;
    if (bus3.data_out !== 16'h5A3C) begin bad++; $display("FAIL ws_rd_data: got %h want 5a3c", bus3.data_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus3.ack !== 1'b1 || bus3.data_out !== 16'h5A3C) begin
        bad++;
        $display("FAIL ws_hold %0d: got ack=%b data=%h want ack=1 data=5a3c", i, bus3.ack, bus3.data_out);
      end
    end
    bus3.cs = 1'b0;
    tick();
    total++;
    if (bus3.ack !== 1'b0) begin bad++; $display("FAIL ws_ack_fall: got %b want 0", bus3.ack); end
    $display("ws=3 read addr=00000040 data=%h lat=%0d held 4 cycles", bus3.data_out, lat);
  endtask

  task automatic test_abort();
    int lat; logic [15:0] d; logic aa;
    set_bus(3, 1'b1, 1'b0, 32'h0000_0040, 2'b11, 16'h9999);
    tick();
    tick();
    bus3.cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (bus3.ack !== 1'b0) begin bad++; $display("FAIL abort_ack %0d: got %b want 0", i, bus3.ack); end
    end
    do_xfer(3, 1'b1, 32'h0000_0040, 2'b00, 16'h0000, lat, d, aa);
    total++;
    if (d !== 16'h5A3C) begin bad++; $display("FAIL abort_data: got %h want 5a3c", d); end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL abort_then_read_latency: got %0d want 5", lat); end
    $display("abort during WAIT, reread -> %h", d);
  endtask

  task automatic test_reset_access();
    int lat; logic [15:0] d; logic aa;
    set_bus(0, 1'b1, 1'b0, 32'h0000_0010, 2'b11, 16'h0000);
    tick();
    reset = 1'b1;
    bus0.cs = 1'b0;
    tick();
    total++;
    if (bus0.ack !== 1'b0) begin bad++; $display("FAIL rst_acc_ack: got %b want 0", bus0.ack); end
    total++;
    if (dut0.r_state !== 2'd0) begin bad++; $display("FAIL rst_acc_state: got %0d want 0", dut0.r_state); end
    total++;
    if (bus0.data_out !== 16'h0000) begin bad++; $display("FAIL rst_acc_dout: got %h want 0000", bus0.data_out); end
    reset = 1'b0;
    tick();
    do_xfer(0, 1'b1, 32'h0000_0010, 2'b00, 16'h0000, lat, d, aa);
    total++;
    if (d !== 16'h1234) begin bad++; $display("FAIL rst_acc_word: got %h want 1234", d); end
    $display("reset in ACCESS, reread -> %h", d);
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [15:0] d1, d2; logic aa;
    do_xfer(0, 1'b1, 32'h0000_0002, 2'b00, 16'h0000, lat1, d1, aa);
    do_xfer(0, 1'b1, 32'h0000_0010, 2'b00, 16'h0000, lat2, d2, aa);
    total++;
    if (d1 !== 16'hA5A5 || d2 !== 16'h1234) begin
      bad++;
      $display("FAIL b2b_data: got %h/%h want a5a5/1234", d1, d2);
    end
    total++;
    if (lat2 !== 2) begin bad++; $display("FAIL b2b_latency: got %0d want 2", lat2); end
    $display("back-to-back reads -> %h %h", d1, d2);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_alias();
    test_wait_hold();
    test_abort();
    test_reset_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/internalram_bus.md
Name: internalram_bus

Overview:
Parametrised on-chip RAM slave for the 68k-side bus, built from per-byte-lane single-port BRAMs.
- Generalises the fixed 16-bit, two-lane, read-only-wired RAM to N byte lanes and configurable depth.
- Adds a bus handshake (select/acknowledge), byte-lane write enables and programmable wait states.
- Sits behind the address decoder; the decoder drives cs for this block's address window.

Parameters:
DATA_WIDTH, 16, bus data width in bits; multiple of 8; LANES = DATA_WIDTH/8.
ADDR_WIDTH, 12, word-address bits; depth = 2^ADDR_WIDTH words.
WAIT_STATES, 0, extra cycles inserted before the BRAM access (0..15).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
cs  in  1  access request; level, held by master until ack seen, then dropped.
rw  in  1  1 = read, 0 = write; sampled with cs.
addr  in  32  byte address; word index = addr[ADDR_WIDTH+log2(LANES)-1 : log2(LANES)]; other bits ignored (aliasing).
be  in  LANES  byte-lane enables, active high; be[i] gates data bits [8i+7:8i].
data_in  in  DATA_WIDTH  write data.
data_out  out  DATA_WIDTH  registered read data.
ack  out  1  transfer acknowledge (DTACK-style, active high).

Behaviour:
- Reset: state IDLE, ack = 0, data_out = 0, wait counter = 0. RAM contents are not cleared.
- Reset has priority over everything. Reset asserted in the ACCESS cycle suppresses the write.
- FSM states: IDLE, WAIT, ACCESS, ACK.
- IDLE, cs = 1 sampled:
  - Latch addr index, rw, be and data_in; load counter = WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else ACCESS.
- WAIT:
  - Decrement counter; go to ACCESS when counter reaches 1.
  - cs = 0 here aborts: return to IDLE, no RAM write, ack stays 0.
- ACCESS: one cycle.
  - Write: each lane with latched be[i] = 1 is written. Lanes with be = 0 keep their contents. be = 0 is a legal no-op write that is still acknowledged.
  - Read: all lanes are read (be ignored). BRAM output is registered into data_out at the end of this cycle.
  - Always proceeds to ACK; cs is not checked here, so the access completes once started.
- ACK:
  - ack = 1 (decoded from state, registered).
  - Stay while cs = 1; on cs = 0 go to IDLE, and ack is 0 from the next cycle.
  - ack is high for at least one cycle even if cs already dropped.
- Latency: ack is first high 2 + WAIT_STATES cycles after the edge that sampled cs = 1 in IDLE.
- Valid data: on reads, data_out is valid whenever ack = 1 and holds until the next read completes. Writes never change data_out.
- Back-to-back: a new request needs cs low for at least one sampled edge (ACK→IDLE) and is then sampled in IDLE. Minimum period is 4 + WAIT_STATES cycles.
- Inputs are ignored outside IDLE, apart from cs in WAIT and ACK.
- Read-after-write to the same word returns the new data, because of the FSM spacing.
- No address range check: addresses outside the window alias modulo the depth.

Test Plan:
- Reset, then idle 5 cycles → ack = 0 and data_out = 0x0000 throughout.
- WAIT_STATES=0, write 0xBEEF to addr 0x0000_0010 with be=2'b11, then read it back → ack rises exactly 2 cycles after cs is sampled; read data_out = 0xBEEF.
- Byte lanes on word 0x10 holding 0xBEEF:
  - write 0x12xx with be=2'b10, read → 0x12EF.
  - write 0xxx34 with be=2'b01, read → 0x1234.
  - write with be=2'b00, read → still 0x1234, and the write was acknowledged.
- WAIT_STATES=3 build: read → ack first high 5 cycles after the sampling edge. Hold cs for 4 extra cycles → ack stays high, data stable; ack falls the cycle after cs drops.
- Aliasing, ADDR_WIDTH=12: write 0xA5A5 to byte address 0x0000_0002, then read 0x0000_2002 → 0xA5A5.
- Abort and reset:
  - WAIT_STATES=3: drop cs during WAIT → no ack; a following read of that word shows the old value.
  - Assert reset in the ACCESS cycle of a write → ack = 0, FSM in IDLE, word unchanged.
